// File: rtl/chess_pkg.sv
// Shared encodings for the chess accelerator move-list sequencer.
package chess_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KICK    = 3'd1,
        ST_COLLECT = 3'd2,
        ST_FINISH  = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    // Move encoding: {from_row, from_col, to_row, to_col}
    localparam int ROW_W  = 3;
    localparam int COL_W  = 3;
    localparam int MOVE_W = 2 * (ROW_W + COL_W);

    // Control register bit indices
    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_RESET = 2;

    // Header word layout
    localparam int HDR_OVERFLOW  = 31;
    localparam int HDR_TIMEOUT   = 30;
    localparam int HDR_COUNT_MSB = 15;
    localparam int HDR_COUNT_LSB = 0;

    function automatic logic [31:0] make_header(input logic ovf, input logic tmo,
                                                input logic [15:0] cnt);
        logic [31:0] h;
        h = '0;
        h[HDR_OVERFLOW] = ovf;
        h[HDR_TIMEOUT]  = tmo;
        h[HDR_COUNT_MSB:HDR_COUNT_LSB] = cnt;
        return h;
    endfunction

endpackage

// File: rtl/move_list_sequencer.sv
// Sequences one move-generation pass: kicks the generator, streams moves into
// the HW-to-SW RAM region, writes a count/status header, then holds done.
module move_list_sequencer
    import chess_pkg::*;
#(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 32,
    parameter int BASE_ADDR      = 16,
    parameter int MAX_MOVES      = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  soft_reset,
    output logic                  done,
    output logic                  busy,
    output logic                  gen_start,
    input  logic                  move_valid,
    input  logic [MOVE_W-1:0]     move_data,
    input  logic                  move_last,
    output logic                  move_ready,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    output logic [15:0]           move_count,
    output logic                  overflow,
    output logic                  timeout
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_e            state_q, state_d;
    logic                  start_q, start_d;
    logic [15:0]           count_q, count_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  overflow_q, overflow_d;
    logic                  timeout_q, timeout_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  gen_start_q, gen_start_d;
    logic                  move_ready_q, move_ready_d;
    logic                  ram_wren_q, ram_wren_d;
    logic [ADDR_WIDTH-1:0] ram_wraddress_q, ram_wraddress_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;

    logic start_edge;
    logic handshake;

    assign start_edge = start && !start_q;
    assign handshake  = move_valid && move_ready_q;

    // Next-state and next-output logic; outputs are decoded from the next
    // state so every output is a flop.
    always_comb begin
        state_d         = state_q;
        start_d         = start;
        count_d         = count_q;
        wdog_d          = wdog_q;
        overflow_d      = overflow_q;
        timeout_d       = timeout_q;
        ram_wren_d      = 1'b0;
        ram_wraddress_d = ram_wraddress_q;
        ram_data_d      = ram_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b0;
                    wdog_d     = '0;
                    state_d    = ST_KICK;
                end
            end
            ST_KICK: begin
                state_d = start ? ST_COLLECT : ST_IDLE;
            end
            ST_COLLECT: begin
                if (!start) begin
                    // Abort: count is kept for debug, no header written.
                    state_d = ST_IDLE;
                end else if (handshake) begin
                    wdog_d = '0;
                    if (count_q < 16'(MAX_MOVES)) begin
                        ram_wren_d      = 1'b1;
                        ram_wraddress_d = ADDR_WIDTH'(BASE_ADDR + 1) + ADDR_WIDTH'(count_q);
                        ram_data_d      = DATA_WIDTH'(move_data);
                        count_d         = count_q + 16'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (move_last) state_d = ST_FINISH;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (wdog_d == WDOG_W'(TIMEOUT_CYCLES)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                ram_wren_d      = 1'b1;
                ram_wraddress_d = ADDR_WIDTH'(BASE_ADDR);
                ram_data_d      = DATA_WIDTH'(make_header(overflow_q, timeout_q, count_q));
                state_d         = ST_DONE;
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Software soft reset wins over everything, including a start edge.
        if (soft_reset) begin
            state_d    = ST_IDLE;
            count_d    = '0;
            overflow_d = 1'b0;
            timeout_d  = 1'b0;
            wdog_d     = '0;
            ram_wren_d = 1'b0;
        end

        done_d       = (state_d == ST_DONE);
        busy_d       = (state_d == ST_KICK) || (state_d == ST_COLLECT) || (state_d == ST_FINISH);
        gen_start_d  = (state_d == ST_KICK);
        move_ready_d = (state_d == ST_COLLECT);
    end

    // State and registered outputs; async reset kills any in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            start_q         <= 1'b0;
            count_q         <= '0;
            wdog_q          <= '0;
            overflow_q      <= 1'b0;
            timeout_q       <= 1'b0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            gen_start_q     <= 1'b0;
            move_ready_q    <= 1'b0;
            ram_wren_q      <= 1'b0;
            ram_wraddress_q <= '0;
            ram_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            start_q         <= start_d;
            count_q         <= count_d;
            wdog_q          <= wdog_d;
            overflow_q      <= overflow_d;
            timeout_q       <= timeout_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            gen_start_q     <= gen_start_d;
            move_ready_q    <= move_ready_d;
            ram_wren_q      <= ram_wren_d;
            ram_wraddress_q <= ram_wraddress_d;
            ram_data_q      <= ram_data_d;
        end
    end

    assign done          = done_q;
    assign busy          = busy_q;
    assign gen_start     = gen_start_q;
    assign move_ready    = move_ready_q;
    assign ram_wren      = ram_wren_q;
    assign ram_wraddress = ram_wraddress_q;
    assign ram_data      = ram_data_q;
    assign move_count    = count_q;
    assign overflow      = overflow_q;
    assign timeout       = timeout_q;

endmodule

// File: doc/move_list_sequencer.md
Name: move_list_sequencer

Overview:
- Controller that sequences one search/move-generation pass for the chess accelerator's Avalon-MM RAM slave.
- Detects the software start edge, kicks the move generator, and streams accepted moves into the HW-to-SW region of the shared RAM write port.
- Writes a count/status header, then holds done until software drops start.
- Sits between the slave's control register bits (start, reset) and the RAM write port, replacing hard-coded test data.

Parameters:
- ADDR_WIDTH, 15: RAM word address width.
- DATA_WIDTH, 32: RAM word width.
- BASE_ADDR, 16: header word address. Moves are stored from BASE_ADDR+1 upward.
- MAX_MOVES, 256: move slots available. Must satisfy BASE_ADDR+MAX_MOVES < 2^ADDR_WIDTH.
- TIMEOUT_CYCLES, 65535: maximum cycles allowed in COLLECT without a move handshake.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: level, control bit 0 from software.
- soft_reset, input, 1: level, control bit 2 from software. Sampled synchronously.
- done, output, 1: pass complete. Maps to control bit 1.
- busy, output, 1: high in KICK, COLLECT and FINISH.
- gen_start, output, 1: one-cycle pulse to the move generator.
- move_valid, input, 1: generator has a move.
- move_data, input, 12: {from_row[2:0], from_col[2:0], to_row[2:0], to_col[2:0]}.
- move_last, input, 1: qualifies the final move of the pass. Meaningful only when move_valid is high.
- move_ready, output, 1: sequencer accepts a move.
- ram_wraddress, output, ADDR_WIDTH: RAM write address.
- ram_data, output, DATA_WIDTH: RAM write data.
- ram_wren, output, 1: RAM write enable.
- move_count, output, 16: moves stored in the current or last pass.
- overflow, output, 1: at least one move was dropped because storage was full.
- timeout, output, 1: the last pass was ended by the watchdog.

Behaviour:
- Reset: all outputs 0, state IDLE, start_q=0, count=0, wdog=0.
- start_q is a one-cycle delayed copy of start. A start edge is start && !start_q.
- All outputs are registered. A handshake in cycle n produces ram_wren=1 in cycle n+1.
- FSM IDLE:
  - On a start edge, clear count, overflow, timeout and wdog, then go to KICK.
  - A start that is held high out of reset is an edge, because start_q resets to 0.
- FSM KICK: gen_start=1 for exactly this one cycle, then go to COLLECT.
- FSM COLLECT:
  - move_ready=1.
  - On move_valid && move_ready with count < MAX_MOVES: ram_wraddress=BASE_ADDR+1+count, ram_data={20'b0, move_data}, ram_wren=1, count+1.
  - On a handshake with count == MAX_MOVES: the move is accepted and dropped, overflow=1, count holds (saturates).
  - A handshake with move_last goes to FINISH. The last move is stored under the same rules.
  - wdog increments on each cycle without a handshake and clears on each handshake.
  - When wdog reaches TIMEOUT_CYCLES, set timeout=1 and go to FINISH.
- FSM FINISH: one cycle. ram_wraddress=BASE_ADDR, ram_data={overflow, timeout, 14'b0, count[15:0]}, ram_wren=1, then go to DONE.
- FSM DONE: done=1 and held. When start is sampled low, go to IDLE; done=0 from the next cycle.
- move_count always reflects count; it is valid in DONE and retained in IDLE.
- Abort: start low in KICK or COLLECT goes to IDLE. No header is written, done stays 0, and count is retained for debug.
- soft_reset high in any state forces IDLE and clears count, overflow, timeout and done. It overrides a simultaneous start edge.
- Asynchronous reset mid-pass: an in-flight RAM write is lost and ram_wren is forced to 0 immediately.
- A start edge is ignored outside IDLE.
- move_valid outside COLLECT is ignored; move_ready is 0 there.
- Address arithmetic is ADDR_WIDTH bits. The parameter constraint guarantees no wrap.

Decomposition:
- chess_pkg holds:
  - the state encoding (IDLE, KICK, COLLECT, FINISH, DONE);
  - the move field widths (3-bit row/col, 12-bit move);
  - control bit indices (START=0, DONE=1, RESET=2);
  - header bit positions (OVERFLOW=31, TIMEOUT=30, COUNT=15:0).
- Single module, no sub-module. The watchdog is an inline counter.

Test Plan:
- Normal pass: start rises, generator supplies 3 moves (0x040, 0x041, 0x042), last on the third.
  - gen_start pulses once.
  - RAM writes 17<-0x040, 18<-0x041, 19<-0x042.
  - Then 16<-0x00000003, followed by done=1.
  - start falls, and done=0 one cycle later.
- Back-pressure-free burst: move_valid held for 5 cycles.
  - Writes land on consecutive cycles at 17..21, each one cycle after its handshake.
  - move_count=5.
- Overflow: MAX_MOVES=4, 6 moves supplied.
  - Addresses 17..20 written; moves 5 and 6 dropped.
  - Header = 0x80000004, overflow=1.
- Timeout: TIMEOUT_CYCLES=10, one move supplied and then nothing.
  - After 10 idle cycles, header at 16 = 0x40000001, timeout=1, done=1.
- Abort and soft reset:
  - start drops after 2 moves: state returns to IDLE, no write to 16, done=0.
  - soft_reset during DONE: done=0 and move_count=0 next cycle.
  - soft_reset with a simultaneous start edge: stays in IDLE.
- Async reset mid-COLLECT: reset asserted between clock edges.
  - ram_wren, move_ready and busy go to 0 immediately.
  - After release, a new start edge runs a clean pass from address 17.
